branch_unit: RTL
================

# branch_unit

Control-flow stage sitting directly downstream of the ALU in the KGP-miniRISC datapath. It consumes the ALU `sign`/`zero`/`carry` outputs together with the decoded branch opcode, and holds the architectural carry flag. It resolves all branch types, owns the fetch PC register, issues a one-cycle squash of the wrong-path instruction on a taken branch, and generates the link write for `bl`.

## Interface
Parameters:
- `ADDR_W`, 32: width of PC, offsets and link data.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `stall`  in  1  downstream hold; freezes PC and all state.
- `in_valid`  in  1  a decoded instruction is present this cycle.
- `in_pc`  in  ADDR_W  address of the presented instruction.
- `br_op`  in  4  branch opcode (package constants).
- `flag_we`  in  1  instruction is an add; capture `alu_carry`.
- `alu_sign`, `alu_zero`, `alu_carry`  in  1 each  ALU flag outputs for this instruction. ALU is driven in pass-`a` mode for `bltz`/`bz`/`bnz`.
- `rs_val`  in  ADDR_W  register operand, used as the target for `br`.
- `offset`  in  ADDR_W  signed PC-relative word offset.
- `pc_out`  out  ADDR_W  fetch address (registered).
- `exec_en`  out  1  instruction is live. Combinational: `in_valid & ~stall & state==RUN`.
- `redirect`  out  1  one-cycle pulse; PC was loaded from a branch target.
- `carry_flag`  out  1  architectural carry flag (registered).
- `link_we`  out  1  one-cycle pulse; write `link_data` to r31.
- `link_data`  out  ADDR_W  return address.

## Operation
- Opcodes: NONE 0000, B 0001, BR 0010, BLTZ 0011, BZ 0100, BNZ 0101, BL 0110, BCY 0111, BNCY 1000. Any other value is treated as NONE.
- Taken conditions:
  - B, BR, BL: always taken.
  - BLTZ: `alu_sign`.
  - BZ: `alu_zero`.
  - BNZ: `~alu_zero`.
  - BCY: `carry_flag`.
  - BNCY: `~carry_flag`.
- Target:
  - BR: `rs_val`.
  - All others: `in_pc + offset`, computed modulo 2^ADDR_W (wraps, no trap).
- Accept condition: `exec_en`. Nothing happens unless the instruction is accepted.
- FSM with two states:
  - RUN: on accept with taken branch, `pc_out <= target`, `redirect <= 1`, next state FLUSH. Otherwise `pc_out <= pc_out + 1`.
  - FLUSH: the wrong-path instruction is dropped (`exec_en = 0`; no flag, link or branch effect). `pc_out <= pc_out + 1` and next state RUN.
  - With `stall` high, the FSM holds its state in both RUN and FLUSH.
- Carry flag: on accept with `flag_we`, `carry_flag <= alu_carry`.
  - BCY/BNCY always test the pre-update registered value.
  - `flag_we` is ignored when `br_op != NONE`.
- Link: on accepted BL, `link_we <= 1` and `link_data <= in_pc + 1` for exactly one cycle.

## Timing
- Reset values: `pc_out = 0`, `carry_flag = 0`, state RUN, `redirect = 0`, `link_we = 0`, `link_data = 0`. `exec_en` follows its equation.
- Latency: a branch accepted in cycle t produces `pc_out = target` and `redirect = 1` at t+1. The instruction presented at t+1 is squashed. Normal issue resumes at t+2.
- `redirect` and `link_we` are single-cycle pulses and deassert at t+2 regardless of `stall`.
- Stall: PC, carry flag, state and link outputs all hold. A stall during FLUSH extends FLUSH until the cycle in which `stall` is low.
- Reset asserted mid-FLUSH or in the redirect cycle: all registers return to reset values immediately (asynchronous). The pending squash is abandoned.
- A back-to-back branch arriving in the FLUSH cycle is squashed and has no effect.

## Structure
- Shared package `branch_pkg`: holds the `br_op` encoding constants and the FSM state enumeration (RUN, FLUSH). The decoder imports the same package.
- Sub-module `branch_cond`: purely combinational evaluation of taken/target from `br_op`, flags, `carry_flag`, `rs_val`, `in_pc` and `offset`.
- Top level: holds the PC, the carry flag, the FSM and the link registers.

## Test plan
- Reset: assert `rst` for 3 cycles → `pc_out = 0`, `carry_flag = 0`, `redirect = 0`, `link_we = 0`. After release, `pc_out` counts 1, 2, 3 with `br_op = NONE`.
- BZ taken: `in_pc = 10`, `offset = -3`, `alu_zero = 1` → next cycle `pc_out = 7` and `redirect = 1`. The following `in_valid` instruction sees `exec_en = 0`; `pc_out = 8` one cycle later.
- Carry path: ADD with `flag_we = 1`, `alu_carry = 1`, then BCY at `in_pc = 20`, `offset = 5` → `pc_out = 25`. Same sequence with `alu_carry = 0` → BCY not taken, `pc_out` increments; BNCY taken.
- BL: `in_pc = 20`, `offset = 100` → at t+1 `link_we = 1`, `link_data = 21`, `pc_out = 120`. `link_we` deasserts at t+2.
- Stall: assert `stall` for 4 cycles during FLUSH → `pc_out` and state hold. The squash still applies to the first unstalled instruction.
- Reset mid-flush: taken BR with `rs_val = 0x40`, then `rst` during FLUSH → `pc_out = 0` and state RUN immediately. First post-reset instruction has `exec_en = 1`.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared branch opcode encodings and control-flow FSM states for the KGP-miniRISC datapath.
package branch_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_NONE = 4'b0000;
  localparam logic [OP_W-1:0] OP_B    = 4'b0001;
  localparam logic [OP_W-1:0] OP_BR   = 4'b0010;
  localparam logic [OP_W-1:0] OP_BLTZ = 4'b0011;
  localparam logic [OP_W-1:0] OP_BZ   = 4'b0100;
  localparam logic [OP_W-1:0] OP_BNZ  = 4'b0101;
  localparam logic [OP_W-1:0] OP_BL   = 4'b0110;
  localparam logic [OP_W-1:0] OP_BCY  = 4'b0111;
  localparam logic [OP_W-1:0] OP_BNCY = 4'b1000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Unlisted encodings decode as NONE, so only 1..8 count as branches.
  function automatic logic is_branch(input logic [OP_W-1:0] op);
    return (op >= OP_B) && (op <= OP_BNCY);
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch resolution: taken decision and target address.
module branch_cond
  import branch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [OP_W-1:0]   br_op,
  input  logic              alu_sign,
  input  logic              alu_zero,
  input  logic              carry_flag,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] offset,
  output logic              taken_c,
  output logic [ADDR_W-1:0] target_c
);

  always_comb begin
    taken_c  = 1'b0;
    target_c = in_pc + offset;
    case (br_op)
      OP_B, OP_BR, OP_BL: taken_c = 1'b1;
      OP_BLTZ:            taken_c = alu_sign;
      OP_BZ:              taken_c = alu_zero;
      OP_BNZ:             taken_c = ~alu_zero;
      OP_BCY:             taken_c = carry_flag;
      OP_BNCY:            taken_c = ~carry_flag;
      default:            taken_c = 1'b0;
    endcase
    if (br_op == OP_BR) begin
      target_c = rs_val;
    end
  end

endmodule

// File: rtl/branch_unit.sv
// Control-flow stage: owns fetch PC, carry flag, one-cycle wrong-path squash and bl link write.
module branch_unit
  import branch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [OP_W-1:0]   br_op,
  input  logic              flag_we,
  input  logic              alu_sign,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic [ADDR_W-1:0] offset,
  output logic [ADDR_W-1:0] pc_out,
  output logic              exec_en,
  output logic              redirect,
  output logic              carry_flag,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_data
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              carry_q, carry_d;
  logic              redirect_q, redirect_d;
  logic              link_we_q, link_we_d;
  logic [ADDR_W-1:0] link_data_q, link_data_d;
  logic              taken_c;
  logic [ADDR_W-1:0] target_c;

  branch_cond #(.ADDR_W(ADDR_W)) u_cond (
    .br_op      (br_op),
    .alu_sign   (alu_sign),
    .alu_zero   (alu_zero),
    .carry_flag (carry_q),
    .rs_val     (rs_val),
    .in_pc      (in_pc),
    .offset     (offset),
    .taken_c    (taken_c),
    .target_c   (target_c)
  );

  // Instruction acceptance; the slot after a taken branch is never accepted.
  assign exec_en = in_valid & ~stall & (state_q == ST_RUN);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    carry_d     = carry_q;
    redirect_d  = 1'b0;
    link_we_d   = 1'b0;
    link_data_d = link_data_q;

    case (state_q)
      ST_RUN: begin
        if (!stall) begin
          if (exec_en && taken_c) begin
            pc_d       = target_c;
            redirect_d = 1'b1;
            state_d    = ST_FLUSH;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (!stall) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_RUN;
        end
      end
    endcase

    // Branch opcodes never write the flag, so BCY/BNCY always see the old value.
    if (exec_en && flag_we && !is_branch(br_op)) begin
      carry_d = alu_carry;
    end

    if (exec_en && (br_op == OP_BL)) begin
      link_we_d   = 1'b1;
      link_data_d = in_pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= '0;
      carry_q     <= 1'b0;
      redirect_q  <= 1'b0;
      link_we_q   <= 1'b0;
      link_data_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      carry_q     <= carry_d;
      redirect_q  <= redirect_d;
      link_we_q   <= link_we_d;
      link_data_q <= link_data_d;
    end
  end

  assign pc_out     = pc_q;
  assign redirect   = redirect_q;
  assign carry_flag = carry_q;
  assign link_we    = link_we_q;
  assign link_data  = link_data_q;

endmodule
